range_scan_ctrl: RTL and testbench

RANGE_SCAN_CTRL -- requirements
Module: range_scan_ctrl

---
 rtl/range_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_range_scan_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/range_scan_ctrl.sv
// Range scan controller: probes every address from min(adr_a,adr_b) up to
// max(adr_a,adr_b), one per downstream handshake, and stops on the first hit.
module range_scan_ctrl #(
   parameter int ADR_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [ADR_W-1:0] adr_a,
   input  logic [ADR_W-1:0] adr_b,
   input  logic             rdy,
   input  logic             hit,
   output logic [ADR_W-1:0] adr_out,
   output logic             adr_valid,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [ADR_W-1:0] found_adr,
   output logic             same,
   output logic [ADR_W:0]   probe_cnt,
   output logic [1:0]       dbg_state
);

   // Handshake: a probe is transferred in any cycle where adr_valid=1 and
   // rdy=1; hit is meaningful only in that cycle. adr_valid never drops
   // without a handshake except on abort or reset.

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [ADR_W-1:0] ADR_ONE = {{(ADR_W-1){1'b0}}, 1'b1};
   localparam logic [ADR_W:0]   CNT_ONE = {{ADR_W{1'b0}}, 1'b1};

   state_t           r_state;
   logic [ADR_W-1:0] r_lo;
   logic [ADR_W-1:0] r_hi;
   logic [ADR_W-1:0] r_cur;
   logic             r_adr_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_found;
   logic [ADR_W-1:0] r_found_adr;
   logic             r_same;
   logic [ADR_W:0]   r_probe_cnt;

   logic [ADR_W-1:0] w_lo;
   logic [ADR_W-1:0] w_hi;
   logic             w_a_le_b;
   logic             w_at_hi;

   assign w_a_le_b = (adr_a <= adr_b);
   assign w_lo     = w_a_le_b ? adr_a : adr_b;
   assign w_hi     = w_a_le_b ? adr_b : adr_a;
   // Terminating at hi before incrementing is what keeps cur from wrapping.
   assign w_at_hi  = (r_cur == r_hi);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_lo        <= '0;
         r_hi        <= '0;
         r_cur       <= '0;
         r_adr_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_found     <= 1'b0;
         r_found_adr <= '0;
         r_same      <= 1'b0;
         r_probe_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_lo        <= w_lo;
                  r_hi        <= w_hi;
                  r_same      <= (adr_a == adr_b);
                  r_cur       <= w_lo;
                  r_found     <= 1'b0;
                  r_found_adr <= '0;
                  r_probe_cnt <= '0;
                  r_adr_valid <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (abort) begin
                  r_found     <= 1'b0;
                  r_adr_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end else if (rdy) begin
                  r_probe_cnt <= r_probe_cnt + CNT_ONE;
                  if (hit) begin
                     r_found     <= 1'b1;
                     r_found_adr <= r_cur;
                     r_adr_valid <= 1'b0;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= S_DONE;
                  end else if (w_at_hi) begin
                     r_adr_valid <= 1'b0;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_cur <= r_cur + ADR_ONE;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_adr_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   // cur only moves inside a scan, so it doubles as the held probe address.
   assign adr_out   = r_cur;
   assign adr_valid = r_adr_valid;
   assign busy      = r_busy;
   assign done      = r_done;
   assign found     = r_found;
   assign found_adr = r_found_adr;
   assign same      = r_same;
   assign probe_cnt = r_probe_cnt;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_range_scan_ctrl.sv
// Bench for range_scan_ctrl: expected probe addresses are queued when a scan
// is started and popped as each handshake is observed.
module tb_range_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, abort, rdy, hit;
   logic [4:0] adr_a, adr_b;
   logic [4:0] adr_out, found_adr;
   logic       adr_valid, busy, done, found, same;
   logic [5:0] probe_cnt;
   logic [1:0] dbg_state;

   logic [4:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   range_scan_ctrl #(.ADR_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .adr_a(adr_a), .adr_b(adr_b), .rdy(rdy), .hit(hit),
      .adr_out(adr_out), .adr_valid(adr_valid), .busy(busy), .done(done),
      .found(found), .found_adr(found_adr), .same(same),
      .probe_cnt(probe_cnt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; rdy = 1'b0; hit = 1'b0;
      adr_a = '0; adr_b = '0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({adr_out, adr_valid, busy, done, found, found_adr, same, probe_cnt} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got out=%0d v=%0d b=%0d d=%0d f=%0d fa=%0d s=%0d pc=%0d, required all 0",
                  adr_out, adr_valid, busy, done, found, found_adr, same, probe_cnt);
      end
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (adr_valid !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: adr_valid=%0d required 0", adr_valid);
      end
   endtask

   // Runs a complete scan; hit_at < 0 means no hit. With toggle, rdy alternates 1,0,...
   task automatic run_scan(input logic [4:0] a, input logic [4:0] b, input int hit_at,
                           input bit toggle, input bit hold_start, input string name);
      logic [4:0] lo, hi, e, prev_out, last;
      logic       exp_found;
      logic [4:0] exp_fadr;
      int         exp_cnt, cyc;
      bit         fin, prev_rdy, r_now;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      exp_found = 1'b0; exp_fadr = '0;
      for (int v = int'(lo); v <= int'(hi); v++) begin
         exp_q.push_back(v[4:0]);
         if (v == hit_at) begin exp_found = 1'b1; exp_fadr = v[4:0]; break; end
      end
      exp_cnt = exp_q.size();
      last = exp_q[exp_q.size()-1];

      @(negedge clk);
      start = 1'b1; adr_a = a; adr_b = b; rdy = 1'b0; hit = 1'b0;
      @(negedge clk);
      start = 1'b0;
      prev_rdy = 1'b1; prev_out = '0; cyc = 0; fin = 1'b0;
      while (!fin && cyc < 300) begin
         if (!adr_valid) fin = 1'b1;
         else begin
            n_tests++;
            if (busy !== 1'b1) begin
               n_fail++; $display("FAIL %s_busy: busy=%0d required 1 while probing", name, busy);
            end
            if (!prev_rdy) begin
               n_tests++;
               if (adr_out !== prev_out) begin
                  n_fail++; $display("FAIL %s_hold: adr_out=%0d required %0d after rdy=0", name, adr_out, prev_out);
               end
            end
            r_now = toggle ? (cyc % 2 == 0) : 1'b1;
            rdy = r_now; hit = 1'b0;
            if (r_now) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++; $display("FAIL %s_extra_probe: adr_out=%0d, required no further probe", name, adr_out);
               end else begin
                  e = exp_q.pop_front();
                  if (adr_out !== e) begin
                     n_fail++; $display("FAIL %s_probe: adr_out=%0d required %0d", name, adr_out, e);
                  end
                  hit = (int'(e) == hit_at);
               end
            end
            prev_rdy = r_now; prev_out = adr_out;
            @(negedge clk);
            cyc++;
         end
      end
      rdy = 1'b0; hit = 1'b0;
      n_tests++;
      if (!fin) begin
         n_fail++; $display("FAIL %s_timeout: scan still active after %0d cycles, required end", name, cyc);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL %s_missing_probes: %0d probes left, required 0", name, exp_q.size());
      end
      exp_q.delete();
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL %s_done: done=%0d busy=%0d required done=1 busy=0", name, done, busy);
      end
      n_tests++;
      if (found !== exp_found || found_adr !== exp_fadr) begin
         n_fail++; $display("FAIL %s_found: found=%0d adr=%0d required %0d adr=%0d", name, found, found_adr, exp_found, exp_fadr);
      end
      n_tests++;
      if (probe_cnt !== 6'(exp_cnt)) begin
         n_fail++; $display("FAIL %s_probe_cnt: got %0d required %0d", name, probe_cnt, exp_cnt);
      end
      n_tests++;
      if (same !== (a == b)) begin
         n_fail++; $display("FAIL %s_same: got %0d required %0d", name, same, (a == b));
      end
      start = hold_start; adr_a = 5'd1; adr_b = 5'd2;
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if (done !== 1'b0 || adr_valid !== 1'b0 || adr_out !== last) begin
         n_fail++; $display("FAIL %s_after_done: done=%0d valid=%0d adr_out=%0d required 0 0 %0d", name, done, adr_valid, adr_out, last);
      end
   endtask

   task automatic test_ordered();       run_scan(5'd3, 5'd7, -1, 1'b0, 1'b0, "ordered");   endtask
   task automatic test_swapped_hit();   run_scan(5'd20, 5'd16, 18, 1'b0, 1'b0, "swapped"); endtask
   task automatic test_equal_top();     run_scan(5'd31, 5'd31, -1, 1'b0, 1'b0, "equal_top"); endtask
   task automatic test_backpressure();  run_scan(5'd0, 5'd31, -1, 1'b1, 1'b0, "backpressure"); endtask

   task automatic test_abort();
      logic [4:0] e;
      for (int v = 2; v <= 9; v++) exp_q.push_back(v[4:0]);
      @(negedge clk);
      start = 1'b1; adr_a = 5'd2; adr_b = 5'd9;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         e = exp_q.pop_front();
         n_tests++;
         if (adr_valid !== 1'b1 || adr_out !== e) begin
            n_fail++; $display("FAIL abort_probe: valid=%0d adr_out=%0d required 1 %0d", adr_valid, adr_out, e);
         end
         rdy = 1'b1;
         start = (i == 1); adr_a = 5'd20; adr_b = 5'd25;
         abort = (i == 3); hit = (i == 3);
         @(negedge clk);
         start = 1'b0;
      end
      rdy = 1'b0; hit = 1'b0;
      n_tests++;
      if (adr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || probe_cnt !== 6'd3) begin
         n_fail++; $display("FAIL abort_effect: v=%0d b=%0d d=%0d f=%0d pc=%0d required 0 0 0 0 3",
                            adr_valid, busy, done, found, probe_cnt);
      end
      @(negedge clk);
      abort = 1'b0;
      n_tests++;
      if (done !== 1'b0 || adr_valid !== 1'b0 || probe_cnt !== 6'd3) begin
         n_fail++; $display("FAIL abort_idle: done=%0d valid=%0d pc=%0d required 0 0 3", done, adr_valid, probe_cnt);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [4:0] e;
      for (int v = 2; v <= 9; v++) exp_q.push_back(v[4:0]);
      @(negedge clk);
      start = 1'b1; adr_a = 5'd9; adr_b = 5'd2;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         n_tests++;
         if (adr_out !== e) begin
            n_fail++; $display("FAIL resetmid_probe: adr_out=%0d required %0d", adr_out, e);
         end
         rdy = 1'b1; hit = (i == 2); reset = (i == 2);
         @(negedge clk);
      end
      rdy = 1'b0; hit = 1'b0; reset = 1'b0;
      n_tests++;
      if ({adr_out, adr_valid, busy, done, found, found_adr, same, probe_cnt} !== 21'd0) begin
         n_fail++; $display("FAIL resetmid_outputs: out=%0d v=%0d b=%0d d=%0d f=%0d fa=%0d s=%0d pc=%0d required all 0",
                            adr_out, adr_valid, busy, done, found, found_adr, same, probe_cnt);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || adr_valid !== 1'b0) begin
         n_fail++; $display("FAIL resetmid_no_done: done=%0d valid=%0d required 0 0", done, adr_valid);
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      run_scan(5'd10, 5'd12, -1, 1'b0, 1'b1, "b2b_first");
      run_scan(5'd12, 5'd10, 11, 1'b0, 1'b0, "b2b_second");
      repeat (3) @(negedge clk);
      n_tests++;
      if (found !== 1'b1 || found_adr !== 5'd11 || probe_cnt !== 6'd2 || same !== 1'b0) begin
         n_fail++; $display("FAIL b2b_hold: f=%0d fa=%0d pc=%0d s=%0d required 1 11 2 0", found, found_adr, probe_cnt, same);
      end
   endtask

   initial begin
      test_reset();
      test_ordered();
      test_swapped_hit();
      test_equal_top();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
